// File: rtl/nco_tone_source_if.sv
`default_nettype none
// ============================================================================
// Module   : nco_tone_source_if
// Brief    : Control and sample-stream bundle of the NCO tone source.
// Revision : 1.0 - initial release
// ============================================================================
interface nco_tone_source_if #(
  parameter int PHASE_W = 32,
  parameter int OUT_W   = 10
);
  logic                      en;
  logic                      clr;
  logic        [PHASE_W-1:0] phase_inc;
  logic        [PHASE_W-1:0] phase_ofs;
  logic signed [OUT_W-1:0]   out;
  logic                      out_valid;

  modport master (
    output en, clr, phase_inc, phase_ofs,
    input  out, out_valid
  );

  modport slave (
    input  en, clr, phase_inc, phase_ofs,
    output out, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/nco_tone_source.sv
`default_nettype none
// ============================================================================
// Module   : nco_tone_source
// Brief    : Phase-accumulator NCO with quarter-wave sine table and a
//            2-stage registered signed sample output.
// Revision : 1.0 - initial release
// ============================================================================
module nco_tone_source #(
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = 8,
  parameter int OUT_W   = 10
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  nco_tone_source_if.slave  bus
);

  localparam int  C_N   = 1 << LUT_AW;
  localparam int  C_AMP = (1 << (OUT_W - 1)) - 1;
  localparam real C_PI  = 3.14159265358979323846;

  // Table entries are constants of the index only; tools fold them away.
  function automatic logic [OUT_W-1:0] f_sine(input int idx);
    real v;
    v = real'(C_AMP) * $sin(C_PI * real'(idx) / real'(2 * C_N));
    return OUT_W'($rtoi(v + 0.5));
  endfunction

  logic        [PHASE_W-1:0]          r_acc;
  logic        [PHASE_W-1:0]          w_ph;
  logic        [PHASE_W-LUT_AW-3:0]   w_unused_ph_lsbs;
  logic        [1:0]                  r_quad;
  logic        [LUT_AW-1:0]           r_addr;
  logic        [OUT_W-1:0]            w_lut [0:C_N];
  logic        [LUT_AW:0]             w_idx;
  logic        [OUT_W-1:0]            w_mag;
  logic signed [OUT_W-1:0]            w_sample;
  logic signed [OUT_W-1:0]            r_out;
  logic        [1:0]                  r_vld;

  generate
    for (genvar gi = 0; gi <= C_N; gi++) begin : g_lut
      assign w_lut[gi] = f_sine(gi);
    end
  endgenerate

  // Phase uses the accumulator value before this edge's update.
  assign w_ph             = r_acc + bus.phase_ofs;
  assign w_unused_ph_lsbs = w_ph[PHASE_W-LUT_AW-3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (bus.clr) begin
      r_acc <= '0;
    end else if (bus.en) begin
      r_acc <= r_acc + bus.phase_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quad <= '0;
      r_addr <= '0;
    end else begin
      r_quad <= w_ph[PHASE_W-1:PHASE_W-2];
      r_addr <= w_ph[PHASE_W-3 -: LUT_AW];
    end
  end

  // Odd quadrants read the table mirrored; a=0 there selects the peak lut[N].
  always_comb begin
    w_idx = r_quad[0] ? (LUT_AW+1)'(C_N) - {1'b0, r_addr} : {1'b0, r_addr};
    w_mag = w_lut[w_idx];
    w_sample = r_quad[1] ? -$signed(w_mag) : $signed(w_mag);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
      r_vld <= '0;
    end else begin
      r_out <= w_sample;
      r_vld <= {r_vld[0], 1'b1};
    end
  end

  assign bus.out       = r_out;
  assign bus.out_valid = r_vld[1];

endmodule
`default_nettype wire

// File: tb/tb_nco_tone_source.sv
`default_nettype none
// ============================================================================
// Module   : tb_nco_tone_source
// Brief    : Directed, table-driven self-checking bench for nco_tone_source.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nco_tone_source;

  localparam logic [31:0] C_Q  = 32'h4000_0000;
  localparam logic [31:0] C_Q4 = 32'h1000_0000;
  localparam logic [31:0] C_3Q = 32'hC000_0000;

  typedef struct {
    logic [31:0] inc;
    logic [31:0] ofs;
    logic        en;
    logic        clr;
    int          exp_out;
    logic        exp_vld;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  vec_t vecs[$];

  nco_tone_source_if #(.PHASE_W(32), .OUT_W(10)) bus ();

  nco_tone_source #(.PHASE_W(32), .LUT_AW(8), .OUT_W(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic add(input logic [31:0] inc, input logic [31:0] ofs,
                     input logic en, input logic clr,
                     input int eo, input logic ev);
    vec_t v;
    v.inc = inc; v.ofs = ofs; v.en = en; v.clr = clr;
    v.exp_out = eo; v.exp_vld = ev;
    vecs.push_back(v);
  endtask

  task automatic run_vec(input int i, input string tag);
    bus.phase_inc = vecs[i].inc;
    bus.phase_ofs = vecs[i].ofs;
    bus.en        = vecs[i].en;
    bus.clr       = vecs[i].clr;
    @(posedge clk);
    #1;
    chk($sformatf("%s%0d_out", tag, i), int'($signed(bus.out)), vecs[i].exp_out);
    chk($sformatf("%s%0d_vld", tag, i), int'(bus.out_valid), int'(vecs[i].exp_vld));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Coarse step after reset release, then freeze and clear.
    add(C_Q, 0, 1, 0,    0, 0);
    add(C_Q, 0, 1, 0,    0, 1);
    add(C_Q, 0, 1, 0,  511, 1);
    add(C_Q, 0, 1, 0,    0, 1);
    add(C_Q, 0, 1, 0, -511, 1);
    add(C_Q, 0, 1, 0,    0, 1);
    add(C_Q, 0, 1, 0,  511, 1);
    add(C_Q, 0, 0, 0,    0, 1);
    add(C_Q, 0, 0, 0, -511, 1);
    add(C_Q, 0, 0, 0, -511, 1);
    add(C_Q, 0, 1, 1, -511, 1);
    add(C_Q, 0, 1, 0, -511, 1);
    add(C_Q, 0, 1, 0,    0, 1);
    add(C_Q, 0, 1, 0,  511, 1);
    // Fine step, 16 samples per period (A=511).
    add(C_Q4, 0, 1, 1,    0, 1);
    add(C_Q4, 0, 1, 0, -511, 1);
    add(C_Q4, 0, 1, 0,    0, 1);
    add(C_Q4, 0, 1, 0,  196, 1);
    add(C_Q4, 0, 1, 0,  361, 1);
    add(C_Q4, 0, 1, 0,  472, 1);
    add(C_Q4, 0, 1, 0,  511, 1);
    add(C_Q4, 0, 1, 0,  472, 1);
    add(C_Q4, 0, 1, 0,  361, 1);
    add(C_Q4, 0, 1, 0,  196, 1);
    add(C_Q4, 0, 1, 0,    0, 1);
    add(C_Q4, 0, 1, 0, -196, 1);
    add(C_Q4, 0, 1, 0, -361, 1);
    add(C_Q4, 0, 1, 0, -472, 1);
    add(C_Q4, 0, 1, 0, -511, 1);
    add(C_Q4, 0, 1, 0, -472, 1);
    // Offset only, including an offset change while frozen.
    add(0, C_Q,  1, 1, -361, 1);
    add(0, C_Q,  1, 0,  472, 1);
    add(0, C_Q,  1, 0,  511, 1);
    add(0, C_Q,  1, 0,  511, 1);
    add(0, C_3Q, 1, 0,  511, 1);
    add(0, C_3Q, 1, 0, -511, 1);
    add(0, C_3Q, 1, 0, -511, 1);
    add(0, C_Q,  0, 0, -511, 1);
    add(0, C_Q,  0, 0,  511, 1);
    // Negative step through accumulator underflow.
    add(C_3Q, 0, 1, 1,  511, 1);
    add(C_3Q, 0, 1, 0,    0, 1);
    add(C_3Q, 0, 1, 0,    0, 1);
    add(C_3Q, 0, 1, 0, -511, 1);
    add(C_3Q, 0, 1, 0,    0, 1);
    add(C_3Q, 0, 1, 0,  511, 1);
    add(C_3Q, 0, 1, 0,    0, 1);
    add(C_3Q, 0, 1, 0, -511, 1);

    rst_n         = 1'b0;
    bus.en        = 1'b1;
    bus.clr       = 1'b0;
    bus.phase_inc = C_Q;
    bus.phase_ofs = '0;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_out", int'($signed(bus.out)), 0);
    chk("reset_vld", int'(bus.out_valid), 0);

    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) run_vec(i, "vec");

    // Asynchronous reset between edges must clear outputs at once.
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_out", int'($signed(bus.out)), 0);
    chk("midrst_vld", int'(bus.out_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_hold_vld", int'(bus.out_valid), 0);

    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) run_vec(i, "restart");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
